// File: rtl/mem_access_ctrl.sv
// M-stage data memory access controller: issues the memory request, stalls the
// F/D/E/M registers until acknowledge or timeout, and captures load data for MEM/WB.
module mem_access_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        i_Clk,
    input  logic        Reset,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic        i_MemAck,
    input  logic [31:0] i_MemRdata,
    input  logic        i_ErrClr,
    output logic        o_MemReq,
    output logic        o_MemWe,
    output logic [31:0] o_ReadData,
    output logic        o_WE_n,
    output logic        o_Bubble,
    output logic        o_BusErr
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_d;
    logic [7:0]  w_wait_cnt_inc;
    logic [31:0] r_read_data;
    logic        r_bus_err;
    logic        w_bus_err_d;

    logic        w_mem_op;
    logic        w_mem_req;
    logic        w_ack;
    logic        w_wait;
    logic        w_timeout;
    logic        w_load_capture;

    assign w_mem_op       = i_MemRead | i_MemWrite;
    // Acknowledge only counts while a request is actually on the bus.
    assign w_ack          = w_mem_req & i_MemAck;
    assign w_wait         = w_mem_req & ~i_MemAck;
    assign w_wait_cnt_inc = r_wait_cnt + 8'd1;
    assign w_timeout      = w_wait & (w_wait_cnt_inc == TIMEOUT);
    assign w_load_capture = w_ack & i_MemRead;

    // State register
    always_ff @(posedge i_Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_mem_op) begin
                    if (w_ack || w_timeout) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (w_ack || w_timeout) begin
                    w_state_d = StDone;
                end
            end
            // The M-stage instruction is still the one just served, so MemOp is ignored.
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Output logic; gated by Reset so nothing is requested while reset is held.
    always_comb begin
        w_mem_req = 1'b0;
        unique case (r_state)
            StIdle:   w_mem_req = w_mem_op;
            StAccess: w_mem_req = 1'b1;
            StDone:   w_mem_req = 1'b0;
            default:  w_mem_req = 1'b0;
        endcase
        w_mem_req = w_mem_req & Reset;
    end

    assign o_MemReq = w_mem_req;
    assign o_MemWe  = w_mem_req & i_MemWrite & ~i_MemRead;
    assign o_WE_n   = w_mem_req;
    assign o_Bubble = w_mem_req;

    // Wait counter: counts unacknowledged request edges, cleared otherwise.
    always_comb begin
        w_wait_cnt_d = 8'd0;
        if (w_wait && !w_timeout) begin
            w_wait_cnt_d = w_wait_cnt_inc;
        end
    end

    always_ff @(posedge i_Clk or negedge Reset) begin
        if (!Reset) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= w_wait_cnt_d;
        end
    end

    always_ff @(posedge i_Clk or negedge Reset) begin
        if (!Reset) begin
            r_read_data <= 32'd0;
        end else if (w_load_capture) begin
            r_read_data <= i_MemRdata;
        end
    end

    // A timeout in the same edge as a clear keeps the error set.
    always_comb begin
        w_bus_err_d = r_bus_err;
        if (w_timeout) begin
            w_bus_err_d = 1'b1;
        end else if (i_ErrClr) begin
            w_bus_err_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge Reset) begin
        if (!Reset) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_bus_err_d;
        end
    end

    assign o_ReadData = r_read_data;
    assign o_BusErr   = r_bus_err;

endmodule
